// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg
//   Shared definitions for the branch resolve controller and the comparison
//   unit beside it: BCU compare codes, a code-valid predicate and the
//   controller state encoding.
package branch_resolve_ctrl_pkg;

    // Compare codes understood by the branch comparison unit. 0..11 are
    // legal; 12..15 are unused and flagged as bad by the controller.
    localparam logic [3:0] BCU_EQ  = 4'h0;
    localparam logic [3:0] BCU_NE  = 4'h1;
    localparam logic [3:0] BCU_LT  = 4'h2;
    localparam logic [3:0] BCU_GE  = 4'h3;
    localparam logic [3:0] BCU_LTU = 4'h4;
    localparam logic [3:0] BCU_GEU = 4'h5;
    localparam logic [3:0] BCU_GT  = 4'h6;
    localparam logic [3:0] BCU_LE  = 4'h7;
    localparam logic [3:0] BCU_GTU = 4'h8;
    localparam logic [3:0] BCU_LEU = 4'h9;
    localparam logic [3:0] BCU_AL  = 4'hA;
    localparam logic [3:0] BCU_NV  = 4'hB;

    // True for any of the twelve defined compare codes.
    function automatic logic bcu_code_valid(input logic [3:0] code);
        return (code <= BCU_NV);
    endfunction

    typedef enum logic [1:0] {
        BRC_IDLE     = 2'd0,
        BRC_WAIT     = 2'd1,
        BRC_RESOLVE  = 2'd2,
        BRC_REDIRECT = 2'd3
    } brc_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// sat_counter
//   Up counter that sticks at all-ones instead of wrapping.
//   clk_i  - clock
//   rst_i  - synchronous active-high clear
//   inc_i  - count enable (one step per cycle)
//   cnt_o  - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Sequences the branch comparison unit from the decode stage. A branch in
//   ID is captured, IF/ID is stalled until forwarded operands are ready, the
//   comparison unit is driven for one resolve cycle and a taken result
//   produces a one-cycle PC redirect plus IF flush.
//   Inputs : clk, rst (sync, active high), id_valid, id_is_branch,
//            id_bcu_ctrl, id_target, ops_ready, bcu_branch
//   Outputs: bcu_ctrl, stall_ifid, flush_if, redirect_valid, redirect_target,
//            branch_cnt, taken_cnt (saturating), bad_ctrl, wait_timeout
//            (both sticky until reset)
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [3:0]       id_bcu_ctrl,
    input  logic [31:0]      id_target,
    input  logic             ops_ready,
    input  logic             bcu_branch,
    output logic [3:0]       bcu_ctrl,
    output logic             stall_ifid,
    output logic             flush_if,
    output logic             redirect_valid,
    output logic [31:0]      redirect_target,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             bad_ctrl,
    output logic             wait_timeout
);

    brc_state_e  state_q;
    logic [3:0]  code_q;
    logic [31:0] tgt_q;
    logic [7:0]  wait_q;
    logic [3:0]  bcu_ctrl_q;
    logic        redirect_q;
    logic [31:0] rtgt_q;
    logic        bad_q;
    logic        timeout_q;

    logic detect;
    logic resolving;
    logic code_ok;
    logic taken;

    assign detect    = id_valid & id_is_branch;
    assign resolving = (state_q == BRC_RESOLVE);
    assign code_ok   = bcu_code_valid(code_q);
    // An invalid code never redirects, whatever the comparison unit says.
    assign taken     = resolving & code_ok & bcu_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BRC_IDLE;
            code_q     <= '0;
            tgt_q      <= '0;
            wait_q     <= '0;
            bcu_ctrl_q <= '0;
            redirect_q <= 1'b0;
            rtgt_q     <= '0;
            bad_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            case (state_q)
                BRC_IDLE: begin
                    if (detect) begin
                        code_q <= id_bcu_ctrl;
                        tgt_q  <= id_target;
                        wait_q <= '0;
                        if (ops_ready) begin
                            // bcu_ctrl is loaded on entry so it is valid
                            // for the whole resolve cycle.
                            bcu_ctrl_q <= id_bcu_ctrl;
                            state_q    <= BRC_RESOLVE;
                        end else begin
                            state_q <= BRC_WAIT;
                        end
                    end
                end
                BRC_WAIT: begin
                    if (ops_ready) begin
                        bcu_ctrl_q <= code_q;
                        state_q    <= BRC_RESOLVE;
                    end else begin
                        if (wait_q != 8'hFF) begin
                            wait_q <= wait_q + 8'd1;
                        end
                        // Still not ready after MAX_WAIT wait cycles: flag it
                        // but keep waiting.
                        if ((int'(wait_q) + 1) >= MAX_WAIT) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                BRC_RESOLVE: begin
                    if (!code_ok) begin
                        bad_q <= 1'b1;
                    end
                    if (taken) begin
                        redirect_q <= 1'b1;
                        rtgt_q     <= tgt_q;
                        state_q    <= BRC_REDIRECT;
                    end else begin
                        state_q <= BRC_IDLE;
                    end
                end
                // A branch in ID now is squashed by flush_if, so it is ignored.
                BRC_REDIRECT: state_q <= BRC_IDLE;
                default:      state_q <= BRC_IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (resolving),
        .cnt_o (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (taken),
        .cnt_o (taken_cnt)
    );

    // The detect term is combinational so IF/ID holds in the same cycle the
    // branch is seen; it cannot overlap a redirect (state is IDLE then).
    assign stall_ifid      = (state_q == BRC_WAIT) | resolving |
                             ((state_q == BRC_IDLE) & detect);
    assign bcu_ctrl        = bcu_ctrl_q;
    assign flush_if        = redirect_q;
    assign redirect_valid  = redirect_q;
    assign redirect_target = rtgt_q;
    assign bad_ctrl        = bad_q;
    assign wait_timeout    = timeout_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_is_branch, ops_ready, bcu_branch;
    logic [3:0]  id_bcu_ctrl;
    logic [31:0] id_target;

    logic [3:0]  bcu_ctrl, bcu_ctrl_s;
    logic        stall_ifid, flush_if, redirect_valid;
    logic        stall_ifid_s, flush_if_s, redirect_valid_s;
    logic [31:0] redirect_target, redirect_target_s;
    logic [15:0] branch_cnt, taken_cnt;
    logic [1:0]  branch_cnt_s, taken_cnt_s;
    logic        bad_ctrl, wait_timeout, bad_ctrl_s, wait_timeout_s;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.MAX_WAIT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_bcu_ctrl(id_bcu_ctrl), .id_target(id_target), .ops_ready(ops_ready),
        .bcu_branch(bcu_branch), .bcu_ctrl(bcu_ctrl), .stall_ifid(stall_ifid),
        .flush_if(flush_if), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .branch_cnt(branch_cnt),
        .taken_cnt(taken_cnt), .bad_ctrl(bad_ctrl), .wait_timeout(wait_timeout)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation checks.
    branch_resolve_ctrl #(.MAX_WAIT(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_bcu_ctrl(id_bcu_ctrl), .id_target(id_target), .ops_ready(ops_ready),
        .bcu_branch(bcu_branch), .bcu_ctrl(bcu_ctrl_s), .stall_ifid(stall_ifid_s),
        .flush_if(flush_if_s), .redirect_valid(redirect_valid_s),
        .redirect_target(redirect_target_s), .branch_cnt(branch_cnt_s),
        .taken_cnt(taken_cnt_s), .bad_ctrl(bad_ctrl_s), .wait_timeout(wait_timeout_s)
    );

    typedef struct {
        logic        v, br;
        logic [3:0]  c;
        logic [31:0] t;
        logic        ops, bb;
        logic        st, fl, rv;
        logic [31:0] rt;
        logic [3:0]  bctl;
        logic [15:0] bc, tc;
        logic        bad, to;
    } vec_t;

    vec_t tv[23];

    function automatic vec_t mk(input logic v, br, input logic [3:0] c,
                                input logic [31:0] t, input logic ops, bb,
                                input logic st, fl, rv, input logic [31:0] rt,
                                input logic [3:0] bctl, input logic [15:0] bc, tc,
                                input logic bad, to);
        vec_t r;
        r.v = v; r.br = br; r.c = c; r.t = t; r.ops = ops; r.bb = bb;
        r.st = st; r.fl = fl; r.rv = rv; r.rt = rt; r.bctl = bctl;
        r.bc = bc; r.tc = tc; r.bad = bad; r.to = to;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle: inputs change away from the rising edge, outputs sampled
    // 2 time units later, still before the next rising edge.
    task automatic step(input logic r, v, br, input logic [3:0] c,
                        input logic [31:0] t, input logic ops, bb);
        @(negedge clk);
        rst = r; id_valid = v; id_is_branch = br; id_bcu_ctrl = c;
        id_target = t; ops_ready = ops; bcu_branch = bb;
        #2;
    endtask

    task automatic chk_all(input string nm, input vec_t e);
        chk({nm, ".stall"},    {31'd0, stall_ifid},     {31'd0, e.st});
        chk({nm, ".flush"},    {31'd0, flush_if},       {31'd0, e.fl});
        chk({nm, ".redir"},    {31'd0, redirect_valid}, {31'd0, e.rv});
        chk({nm, ".rtgt"},     redirect_target,         e.rt);
        chk({nm, ".bcu_ctrl"}, {28'd0, bcu_ctrl},       {28'd0, e.bctl});
        chk({nm, ".brcnt"},    {16'd0, branch_cnt},     {16'd0, e.bc});
        chk({nm, ".tkcnt"},    {16'd0, taken_cnt},      {16'd0, e.tc});
        chk({nm, ".bad"},      {31'd0, bad_ctrl},       {31'd0, e.bad});
        chk({nm, ".timeout"},  {31'd0, wait_timeout},   {31'd0, e.to});
    endtask

    task automatic chk_zero(input string nm);
        chk_all(nm, mk(0,0,0,0,0,0, 0,0,0,32'h0,4'h0,16'd0,16'd0,0,0));
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_is_branch = 0; id_bcu_ctrl = 0;
        id_target = 0; ops_ready = 0; bcu_branch = 0;

        //            v br c        tgt     ops bb | st fl rv rtgt   bctl     bc tc bad to
        // BEQ taken, operands ready
        tv[0]  = mk(1,1,BCU_EQ, 32'h40, 1,0, 1,0,0,32'h0,  BCU_EQ,0,0,0,0);
        tv[1]  = mk(0,0,4'h0,   32'h0,  0,1, 1,0,0,32'h0,  BCU_EQ,0,0,0,0);
        tv[2]  = mk(0,0,4'h0,   32'h0,  0,0, 0,1,1,32'h40, BCU_EQ,1,1,0,0);
        tv[3]  = mk(0,0,4'h0,   32'h0,  0,0, 0,0,0,32'h40, BCU_EQ,1,1,0,0);
        // BNE not taken
        tv[4]  = mk(1,1,BCU_NE, 32'h80, 1,0, 1,0,0,32'h40, BCU_EQ,1,1,0,0);
        tv[5]  = mk(0,0,4'h0,   32'h0,  0,0, 1,0,0,32'h40, BCU_NE,1,1,0,0);
        tv[6]  = mk(0,0,4'h0,   32'h0,  0,0, 0,0,0,32'h40, BCU_NE,2,1,0,0);
        // BLT taken after 3 cycles with operands not ready
        tv[7]  = mk(1,1,BCU_LT, 32'h100,0,0, 1,0,0,32'h40, BCU_NE,2,1,0,0);
        tv[8]  = mk(0,0,4'h0,   32'h0,  0,0, 1,0,0,32'h40, BCU_NE,2,1,0,0);
        tv[9]  = mk(0,0,4'h0,   32'h0,  0,0, 1,0,0,32'h40, BCU_NE,2,1,0,0);
        tv[10] = mk(0,0,4'h0,   32'h0,  1,0, 1,0,0,32'h40, BCU_NE,2,1,0,0);
        tv[11] = mk(0,0,4'h0,   32'h0,  0,1, 1,0,0,32'h40, BCU_LT,2,1,0,0);
        tv[12] = mk(0,0,4'h0,   32'h0,  0,0, 0,1,1,32'h100,BCU_LT,3,2,0,0);
        tv[13] = mk(0,0,4'h0,   32'h0,  0,0, 0,0,0,32'h100,BCU_LT,3,2,0,0);
        // Invalid code 0xF with a "taken" compare result: not taken, bad_ctrl
        tv[14] = mk(1,1,4'hF,   32'h200,1,1, 1,0,0,32'h100,BCU_LT,3,2,0,0);
        tv[15] = mk(0,0,4'h0,   32'h0,  0,1, 1,0,0,32'h100,4'hF,  3,2,0,0);
        tv[16] = mk(0,0,4'h0,   32'h0,  0,0, 0,0,0,32'h100,4'hF,  4,2,1,0);
        // Branch held in ID through the redirect is ignored, then re-detected
        tv[17] = mk(1,1,BCU_GE, 32'h300,1,0, 1,0,0,32'h100,4'hF,  4,2,1,0);
        tv[18] = mk(1,1,BCU_GE, 32'h300,1,1, 1,0,0,32'h100,BCU_GE,4,2,1,0);
        tv[19] = mk(1,1,BCU_GE, 32'h300,1,0, 0,1,1,32'h300,BCU_GE,5,3,1,0);
        tv[20] = mk(1,1,BCU_GE, 32'h300,1,0, 1,0,0,32'h300,BCU_GE,5,3,1,0);
        tv[21] = mk(0,0,4'h0,   32'h0,  0,0, 1,0,0,32'h300,BCU_GE,5,3,1,0);
        // Non-branch in ID does not stall
        tv[22] = mk(1,0,4'h0,   32'h0,  0,0, 0,0,0,32'h300,BCU_GE,6,3,1,0);

        step(1,0,0,0,0,0,0);
        step(1,0,0,0,0,0,0);
        step(0,0,0,0,0,0,0);
        chk_zero("reset");

        for (int i = 0; i < 23; i++) begin
            step(0, tv[i].v, tv[i].br, tv[i].c, tv[i].t, tv[i].ops, tv[i].bb);
            chk_all($sformatf("vec%0d", i), tv[i]);
        end

        // Timeout: operands not ready for 9 cycles (detect + 8 wait cycles).
        step(1,0,0,0,0,0,0);
        step(0,1,1,BCU_LT,32'h500,0,0);
        for (int i = 0; i < 8; i++) begin
            step(0,0,0,0,0,0,0);
            chk($sformatf("to_wait%0d.stall", i), {31'd0, stall_ifid}, 32'd1);
        end
        step(0,0,0,0,0,1,0);
        chk("to.flag", {31'd0, wait_timeout}, 32'd1);
        chk("to.stall", {31'd0, stall_ifid}, 32'd1);
        step(0,0,0,0,0,0,1);                       // RESOLVE, taken
        chk("to.resolve_bctl", {28'd0, bcu_ctrl}, {28'd0, BCU_LT});
        step(0,0,0,0,0,0,0);                       // REDIRECT
        chk("to.redir", {31'd0, redirect_valid}, 32'd1);
        chk("to.rtgt", redirect_target, 32'h500);
        chk("to.sticky", {31'd0, wait_timeout}, 32'd1);

        // Reset while in WAIT_OPS clears everything, including sticky flags.
        step(0,1,1,BCU_NE,32'h600,0,0);
        step(1,0,0,0,0,0,0);                       // WAIT cycle, rst asserted
        step(0,0,0,0,0,1,1);
        chk_zero("rst_wait");
        step(0,0,0,0,0,0,1);
        chk("rst_wait.no_redir", {31'd0, redirect_valid}, 32'd0);

        // Reset while in REDIRECT: next cycle is all-zero, no further pulse.
        step(0,1,1,BCU_EQ,32'h44,1,0);
        step(0,0,0,0,0,0,1);
        step(1,0,0,0,0,0,0);
        chk("rst_redir.pulse", {31'd0, redirect_valid}, 32'd1);
        step(0,0,0,0,0,0,0);
        chk_zero("rst_redir");
        step(0,0,0,0,0,0,0);
        chk("rst_redir.after", {31'd0, redirect_valid}, 32'd0);

        // Saturation: 5 taken branches into a 2-bit counter.
        step(1,0,0,0,0,0,0);
        for (int i = 0; i < 5; i++) begin
            step(0,1,1,BCU_EQ,32'h80,1,0);
            step(0,0,0,0,0,0,1);
            step(0,0,0,0,0,0,0);
            chk($sformatf("sat%0d.redir", i), {31'd0, redirect_valid_s}, 32'd1);
        end
        step(0,0,0,0,0,0,0);
        chk("sat.brcnt_2b", {30'd0, branch_cnt_s}, 32'd3);
        chk("sat.tkcnt_2b", {30'd0, taken_cnt_s}, 32'd3);
        chk("sat.brcnt_16b", {16'd0, branch_cnt}, 32'd5);
        chk("sat.tkcnt_16b", {16'd0, taken_cnt}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
